stdout_uart_tx: RTL and testbench

//  Downstream consumer of the TOY system's stdout stream (val/rdy, 16-bit words).

---
 rtl/toy_uart_pkg.sv | 21 ++
 rtl/uart_tx_byte.sv | 61 ++++++
 rtl/stdout_uart_tx.sv | 95 +++++++++
 tb/tb_stdout_uart_tx.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/toy_uart_pkg.sv
// Shared constants, FSM state type and nibble-to-ASCII helper for the stdout UART.
package toy_uart_pkg;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;

    typedef enum logic [0:0] {
        IDLE,
        SEND
    } uart_state_e;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_0 + {4'd0, nib};
        end
        return ASCII_A + {4'd0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser. A start request on the final stop-bit cycle chains the next
// frame with no idle gap.
module uart_tx_byte
    import toy_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] byte_i,
    output logic       tx_o,
    output logic       done_o
);

    localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    logic             active;
    logic [3:0]       bit_cnt;
    logic [BaudW-1:0] baud;
    logic [7:0]       shift;

    // bit_cnt: 0 = start bit, 1..8 = data, 9 = stop bit
    assign done_o = active && (bit_cnt == 4'd9) && (baud == BaudLast);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            active  <= 1'b0;
            bit_cnt <= '0;
            baud    <= '0;
            shift   <= '0;
            tx_o    <= 1'b1;
        end else if (start_i) begin
            active  <= 1'b1;
            bit_cnt <= '0;
            baud    <= '0;
            shift   <= byte_i;
            tx_o    <= 1'b0;
        end else if (active) begin
            if (baud == BaudLast) begin
                baud <= '0;
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                    tx_o   <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd8) begin
                        tx_o <= 1'b1;
                    end else begin
                        tx_o  <= shift[0];
                        shift <= {1'b0, shift[7:1]};
                    end
                end
            end else begin
                baud <= baud + BaudW'(1);
            end
        end
    end

endmodule

// File: rtl/stdout_uart_tx.sv
// Prints each accepted 16-bit stdout word as four hex digits plus end-of-line over
// an 8N1 UART; the core is back-pressured for the whole duration of a word.
module stdout_uart_tx
    import toy_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter bit          EOL_CRLF     = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        stdout_val_i,
    input  logic [15:0] stdout_data_i,
    output logic        stdout_rdy_o,
    output logic        uart_tx_o,
    output logic        busy_o
);

    localparam logic [2:0] LastIdx = EOL_CRLF ? 3'd5 : 3'd4;

    uart_state_e state;
    logic [15:0] word;
    logic [2:0]  char_idx;
    logic        rdy;
    logic        byte_start;
    logic [7:0]  byte_data;
    logic        byte_done;

    function automatic logic [7:0] char_at(input logic [2:0] idx, input logic [15:0] w);
        case (idx)
            3'd0:    return hex_ascii(w[15:12]);
            3'd1:    return hex_ascii(w[11:8]);
            3'd2:    return hex_ascii(w[7:4]);
            3'd3:    return hex_ascii(w[3:0]);
            3'd4:    return EOL_CRLF ? ASCII_CR : ASCII_LF;
            default: return ASCII_LF;
        endcase
    endfunction

    // Char 0 starts straight from the input bus so its start bit follows the accept edge.
    always_comb begin
        byte_start = 1'b0;
        byte_data  = hex_ascii(stdout_data_i[15:12]);
        if (state == IDLE) begin
            byte_start = stdout_val_i;
        end else if (byte_done && (char_idx != LastIdx)) begin
            byte_start = 1'b1;
            byte_data  = char_at(char_idx + 3'd1, word);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            word     <= '0;
            char_idx <= '0;
            rdy      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (stdout_val_i) begin
                        state    <= SEND;
                        word     <= stdout_data_i;
                        char_idx <= '0;
                        rdy      <= 1'b0;
                    end
                end
                SEND: begin
                    if (byte_done) begin
                        if (char_idx == LastIdx) begin
                            state <= IDLE;
                            rdy   <= 1'b1;
                        end else begin
                            char_idx <= char_idx + 3'd1;
                        end
                    end
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .start_i(byte_start),
        .byte_i (byte_data),
        .tx_o   (uart_tx_o),
        .done_o (byte_done)
    );

    assign stdout_rdy_o = rdy;
    assign busy_o       = ~rdy;

endmodule

// File: tb/tb_stdout_uart_tx.sv
// Bench for stdout_uart_tx: decodes the serial line and scores bytes against a queue
// of expected characters pushed at each accept.
module tb_stdout_uart_tx;

    localparam int CLKS = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        val, val_lf;
    logic [15:0] data, data_lf;
    logic        rdy, tx, busy;
    logic        rdy_lf, tx_lf, busy_lf;
    bit          sel_lf = 1'b0;
    logic        mon_tx, cur_rdy, cur_busy;

    int          cyc = 0;
    int          epoch = 0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    int          frame_starts[$];

    typedef struct packed {
        logic [15:0] data;
        logic [47:0] bytes;
    } vec_t;
    vec_t vecs [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    stdout_uart_tx #(
        .CLKS_PER_BIT(CLKS),
        .EOL_CRLF    (1'b1)
    ) dut (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .stdout_val_i (val),
        .stdout_data_i(data),
        .stdout_rdy_o (rdy),
        .uart_tx_o    (tx),
        .busy_o       (busy)
    );

    stdout_uart_tx #(
        .CLKS_PER_BIT(CLKS),
        .EOL_CRLF    (1'b0)
    ) dut_lf (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .stdout_val_i (val_lf),
        .stdout_data_i(data_lf),
        .stdout_rdy_o (rdy_lf),
        .uart_tx_o    (tx_lf),
        .busy_o       (busy_lf)
    );

    assign mon_tx   = sel_lf ? tx_lf : tx;
    assign cur_rdy  = sel_lf ? rdy_lf : rdy;
    assign cur_busy = sel_lf ? busy_lf : busy;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_word(input logic [15:0] d, input bit crlf);
        string hexd;
        hexd = "0123456789ABCDEF";
        for (int i = 3; i >= 0; i--) exp_q.push_back(hexd[d[i*4 +: 4]]);
        if (crlf) exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic wait_rdy(input int limit, output int at);
        int n;
        n = 0;
        @(negedge clk);
        while (cur_rdy !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (cur_rdy !== 1'b1) check("rdy_timeout", {31'd0, cur_rdy}, 32'd1);
        at = cyc;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic set_in(input logic v, input logic [15:0] d);
        if (sel_lf) begin
            val_lf  = v;
            data_lf = d;
        end else begin
            val  = v;
            data = d;
        end
    endtask

    task automatic send_word(input logic [15:0] d, output int acc);
        int t;
        wait_rdy(2000, t);
        set_in(1'b1, d);
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        set_in(1'b0, 16'($urandom));
        check("rdy_drop", {31'd0, cur_rdy}, 32'd0);
        check("busy_set", {31'd0, cur_busy}, 32'd1);
    endtask

    // Line decoder: samples mid-bit; frames overlapping a reset are discarded.
    initial begin : monitor
        int         ep, st;
        logic [7:0] b, e;
        logic       sb, pb;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && mon_tx === 1'b0) begin
                ep = epoch;
                st = cyc;
                repeat (CLKS / 2) @(negedge clk);
                sb = mon_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (CLKS) @(negedge clk);
                    b[i] = mon_tx;
                end
                repeat (CLKS) @(negedge clk);
                pb = mon_tx;
                if (ep == epoch && rst_n === 1'b1) begin
                    frame_starts.push_back(st);
                    check("start_bit", {31'd0, sb}, 32'd0);
                    check("stop_bit", {31'd0, pb}, 32'd1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h want none (cycle %0d)", b, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", {24'd0, b}, {24'd0, e});
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int acc, r, n;
        int acc3 [3];
        logic [15:0] w3 [3];

        vecs[0] = '{data: 16'h1234, bytes: 48'h31_32_33_34_0D_0A};
        vecs[1] = '{data: 16'hABCF, bytes: 48'h41_42_43_46_0D_0A};
        vecs[2] = '{data: 16'h0000, bytes: 48'h30_30_30_30_0D_0A};
        vecs[3] = '{data: 16'h9A0F, bytes: 48'h39_41_30_46_0D_0A};
        w3[0] = 16'hC0DE;
        w3[1] = 16'h0F1E;
        w3[2] = 16'h8D2B;

        rst_n = 1'b0;
        val = 1'b0; val_lf = 1'b0;
        data = '0; data_lf = '0;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_rdy", {31'd0, rdy}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_tx", {31'd0, tx}, 32'd1);
        check("idle_rdy", {31'd0, rdy}, 32'd1);

        // Single words from the table: bytes, first start bit, latency
        for (int v = 0; v < 4; v++) begin
            frame_starts.delete();
            send_word(vecs[v].data, acc);
            for (int j = 0; j < 6; j++) exp_q.push_back(vecs[v].bytes[47 - 8*j -: 8]);
            wait_rdy(400, r);
            check("rdy_latency", r - acc, 240);
            wait_drain();
            check("frame_count", frame_starts.size(), 6);
            if (frame_starts.size() > 0) check("first_start", frame_starts[0], acc);
        end

        // Val held high across three words
        frame_starts.delete();
        wait_rdy(400, r);
        val  = 1'b1;
        data = w3[0];
        for (int k = 0; k < 3; k++) begin
            if (k > 0) wait_rdy(400, r);
            @(posedge clk);
            #1 acc3[k] = cyc;
            push_word(w3[k], 1'b1);
            if (k < 2) data = w3[k+1];
            else begin
                val  = 1'b0;
                data = '0;
            end
        end
        check("period_01", acc3[1] - acc3[0], 241);
        check("period_12", acc3[2] - acc3[1], 241);
        wait_rdy(400, r);
        wait_drain();
        check("held_frames", frame_starts.size(), 18);
        if (frame_starts.size() == 18) begin
            for (int k = 0; k < 3; k++)
                for (int j = 0; j < 6; j++)
                    check("frame_start", frame_starts[6*k + j], acc3[k] + 40*j);
        end

        // Val toggling and data churn while busy
        send_word(16'h5A3C, acc);
        push_word(16'h5A3C, 1'b1);
        n = 0;
        while (rdy !== 1'b1 && n < 400) begin
            val  = 1'($urandom);
            data = 16'($urandom);
            @(negedge clk);
            n++;
        end
        val = 1'b0;
        check("toggle_latency", cyc - acc, 240);
        repeat (50) @(negedge clk);
        check("toggle_no_accept", {31'd0, rdy}, 32'd1);
        wait_drain();

        // Reset in the middle of char 2
        send_word(16'h7E51, acc);
        push_word(16'h7E51, 1'b1);
        repeat (95) @(negedge clk);
        check("busy_before_rst", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        epoch++;
        exp_q.delete();
        #1;
        check("rst_tx_async", {31'd0, tx}, 32'd1);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rdy", {31'd0, rdy}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tx", {31'd0, tx}, 32'd1);
        repeat (60) @(negedge clk);
        check("rst_quiet", {31'd0, tx}, 32'd1);
        send_word(16'hFFFF, acc);
        push_word(16'hFFFF, 1'b1);
        wait_rdy(400, r);
        check("post_rst_latency", r - acc, 240);
        wait_drain();

        // LF-only instance
        sel_lf = 1'b1;
        send_word(16'h00FF, acc);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h46);
        exp_q.push_back(8'h46);
        exp_q.push_back(8'h0A);
        wait_rdy(400, r);
        check("lf_latency", r - acc, 200);
        wait_drain();
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
